// File: rtl/swipt_pkg.sv
// Shared widths, defaults and FSM state type for the SWIPT receive-side link meter.
package swipt_pkg;

    localparam int unsigned FREQ_W         = 32;
    localparam int unsigned DUTY_W         = 12;
    localparam int unsigned CLK_HZ_DEFAULT = 100_000_000;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } meter_state_t;

endpackage

// File: rtl/swipt_div32.sv
// Sequential unsigned 32/32 restoring divider, one quotient bit per cycle.
// The start cycle computes the first bit, so done rises on the 33rd cycle counting start.
module swipt_div32
    import swipt_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              abort,
    input  logic [FREQ_W-1:0] dividend,
    input  logic [FREQ_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [FREQ_W-1:0] quotient
);

    logic [FREQ_W-1:0] rem_q, quo_q, dvs_q;
    logic [4:0]        steps_q;
    logic              busy_q, done_q;

    logic [FREQ_W-1:0] rem_in, quo_in, dvs_in, rem_step, quo_step;
    logic [FREQ_W:0]   shifted;

    // One restoring step; on start it works straight from the operands
    always_comb begin
        rem_in  = start ? '0 : rem_q;
        quo_in  = start ? dividend : quo_q;
        dvs_in  = start ? divisor : dvs_q;
        shifted = {rem_in, quo_in[FREQ_W-1]};
        if (shifted >= {1'b0, dvs_in}) begin
            rem_step = FREQ_W'(shifted - {1'b0, dvs_in});
            quo_step = {quo_in[FREQ_W-2:0], 1'b1};
        end else begin
            // Top bit is zero here because the remainder is always below the divisor
            rem_step = shifted[FREQ_W-1:0];
            quo_step = {quo_in[FREQ_W-2:0], 1'b0};
        end
    end

    // Iteration registers; abort kills a division in flight without a done pulse
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            steps_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (abort) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (start) begin
            rem_q   <= rem_step;
            quo_q   <= quo_step;
            dvs_q   <= divisor;
            steps_q <= 5'd31;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else if (busy_q) begin
            rem_q   <= rem_step;
            quo_q   <= quo_step;
            steps_q <= steps_q - 5'd1;
            done_q  <= (steps_q == 5'd1);
            if (steps_q == 5'd1) begin
                busy_q <= 1'b0;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/swipt_link_meter.sv
// Receive-side SWIPT link meter: measures period and high time of the sliced link signal,
// reports frequency in Hz and high time in cycles, and tracks lock and loss of signal.
module swipt_link_meter
    import swipt_pkg::*;
#(
    parameter int unsigned CLK_HZ     = CLK_HZ_DEFAULT,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned TIMEOUT    = 20000,
    parameter int unsigned MIN_PERIOD = 40,
    parameter int unsigned TOL        = 8,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              swiptAlive,
    input  logic              link,
    output logic [FREQ_W-1:0] freq_meas,
    output logic [DUTY_W-1:0] high_meas,
    output logic              meas_valid,
    output logic              locked,
    output logic              timeout
);

    localparam int unsigned        MATCH_W   = $clog2(LOCK_COUNT + 1);
    localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0]   TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]   MIN_P     = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0]   TOL_C     = CNT_W'(TOL);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [DUTY_W-1:0]  HCNT_ONE  = DUTY_W'(1);
    localparam logic [FREQ_W-1:0]  DIVIDEND  = FREQ_W'(CLK_HZ);

    logic sync1_q, sync2_q, prev_q;
    logic rise, fall;

    meter_state_t       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DUTY_W-1:0]  hcnt_q, hcnt_d;
    logic               fall_seen_q, fall_seen_d;
    logic [CNT_W-1:0]   p_cap_q, p_cap_d;
    logic [DUTY_W-1:0]  h_cap_q, h_cap_d;
    logic               start_q, start_d;
    logic [CNT_W-1:0]   p_prev_q, p_prev_d;
    logic               prev_valid_q, prev_valid_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic               locked_q, locked_d;
    logic [FREQ_W-1:0]  freq_q, freq_d;
    logic [DUTY_W-1:0]  high_q, high_d;
    logic               meas_valid_q, meas_valid_d;
    logic               timeout_q, timeout_d;

    logic [CNT_W-1:0]  p_diff;
    logic              period_close;
    logic              div_busy, div_done;
    logic [FREQ_W-1:0] div_quot;

    // Two-flop synchronizer plus the previous-sample register for edge detection
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= link;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise = sync2_q & ~prev_q;
    assign fall = ~sync2_q & prev_q;

    // Absolute difference between the period being reported and the one before it
    always_comb begin
        p_diff = (p_cap_q >= p_prev_q) ? (p_cap_q - p_prev_q) : (p_prev_q - p_cap_q);
    end

    assign period_close = (p_diff <= TOL_C);

    swipt_div32 u_div (
        .clk      (clk),
        .nrst     (nrst),
        .start    (start_q),
        .abort    (~swiptAlive),
        .dividend (DIVIDEND),
        .divisor  (FREQ_W'(p_cap_q)),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    // Next state: measurement FSM, divider result handling and lock tracking
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hcnt_d       = hcnt_q;
        fall_seen_d  = fall_seen_q;
        p_cap_d      = p_cap_q;
        h_cap_d      = h_cap_q;
        start_d      = 1'b0;
        p_prev_d     = p_prev_q;
        prev_valid_d = prev_valid_q;
        match_d      = match_q;
        locked_d     = locked_q;
        freq_d       = freq_q;
        high_d       = high_q;
        meas_valid_d = 1'b0;
        timeout_d    = 1'b0;

        if (div_done) begin
            freq_d       = div_quot;
            high_d       = h_cap_q;
            meas_valid_d = 1'b1;
            if (prev_valid_q && period_close) begin
                match_d = (match_q == MATCH_MAX) ? match_q : match_q + 1'b1;
            end else begin
                match_d = '0;
            end
            p_prev_d     = p_cap_q;
            prev_valid_d = 1'b1;
            locked_d     = (match_d >= MATCH_MAX);
        end

        unique case (state_q)
            IDLE: begin
                if (swiptAlive) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (rise) begin
                    state_d     = MEASURE;
                    cnt_d       = CNT_ONE;
                    hcnt_d      = HCNT_ONE;
                    fall_seen_d = 1'b0;
                end
            end
            MEASURE: begin
                if (rise) begin
                    if (cnt_q < MIN_P || !fall_seen_q) begin
                        // Glitch or missing low phase: drop the sample and the lock history
                        match_d  = '0;
                        locked_d = 1'b0;
                    end else begin
                        p_cap_d = cnt_q;
                        h_cap_d = hcnt_q;
                        start_d = ~div_busy;
                    end
                    cnt_d       = CNT_ONE;
                    hcnt_d      = HCNT_ONE;
                    fall_seen_d = 1'b0;
                end else if (cnt_q == TIMEOUT_C) begin
                    timeout_d    = 1'b1;
                    locked_d     = 1'b0;
                    match_d      = '0;
                    prev_valid_d = 1'b0;
                    state_d      = ARM;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (!fall_seen_q && !fall && hcnt_q != '1) begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                    if (fall) begin
                        fall_seen_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Link disabled: back to idle, drop any pending result, keep the last readings
        if (!swiptAlive) begin
            state_d      = IDLE;
            cnt_d        = '0;
            hcnt_d       = '0;
            fall_seen_d  = 1'b0;
            start_d      = 1'b0;
            match_d      = '0;
            locked_d     = 1'b0;
            prev_valid_d = 1'b0;
            p_prev_d     = p_prev_q;
            freq_d       = freq_q;
            high_d       = high_q;
            meas_valid_d = 1'b0;
            timeout_d    = 1'b0;
        end
    end

    // State, counters, captured sample and output registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hcnt_q       <= '0;
            fall_seen_q  <= 1'b0;
            p_cap_q      <= '0;
            h_cap_q      <= '0;
            start_q      <= 1'b0;
            p_prev_q     <= '0;
            prev_valid_q <= 1'b0;
            match_q      <= '0;
            locked_q     <= 1'b0;
            freq_q       <= '0;
            high_q       <= '0;
            meas_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hcnt_q       <= hcnt_d;
            fall_seen_q  <= fall_seen_d;
            p_cap_q      <= p_cap_d;
            h_cap_q      <= h_cap_d;
            start_q      <= start_d;
            p_prev_q     <= p_prev_d;
            prev_valid_q <= prev_valid_d;
            match_q      <= match_d;
            locked_q     <= locked_d;
            freq_q       <= freq_d;
            high_q       <= high_d;
            meas_valid_q <= meas_valid_d;
            timeout_q    <= timeout_d;
        end
    end

    assign freq_meas  = freq_q;
    assign high_meas  = high_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_swipt_link_meter.sv
// Scoreboard bench for swipt_link_meter: stimulus pushes expected results, a monitor pops them.
module tb_swipt_link_meter;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        swiptAlive = 1'b0;
    logic        link = 1'b0;
    logic [31:0] freq_meas;
    logic [11:0] high_meas;
    logic        meas_valid;
    logic        locked;
    logic        timeout;

    swipt_link_meter dut (
        .clk        (clk),
        .nrst       (nrst),
        .swiptAlive (swiptAlive),
        .link       (link),
        .freq_meas  (freq_meas),
        .high_meas  (high_meas),
        .meas_valid (meas_valid),
        .locked     (locked),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int freq;
        int high;
        bit lck;
        int due;
    } exp_t;

    exp_t sb[$];
    int   tq[$];
    int   checks = 0;
    int   failures = 0;

    // Lock model state
    int m = 0;
    bit have_prev = 1'b0;
    int prevp = 0;
    bit open = 1'b0;
    int open_p = 0;
    int open_h = 0;
    int last_rise = 0;
    int last_freq = 0;
    int last_high = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected result of a period closed by a capturing rise driven in cycle due-36
    task automatic close_period(input int p, input int h, input int due);
        exp_t e;
        int   d;
        d = (p > prevp) ? p - prevp : prevp - p;
        if (have_prev && d <= 8) m = (m < 4) ? m + 1 : 4;
        else m = 0;
        have_prev = 1'b1;
        prevp = p;
        e.freq = 100_000_000 / p;
        e.high = (h > 4095) ? 4095 : h;
        e.lck = (m >= 4);
        e.due = due;
        sb.push_back(e);
        last_freq = e.freq;
        last_high = e.high;
    endtask

    // One link cycle: rise now, fall after h cycles, next rise p cycles after this one
    task automatic emit(input int p, input int h);
        @(posedge clk);
        #1 link = 1'b1;
        last_rise = cyc;
        if (open) close_period(open_p, open_h, cyc + 36);
        open = 1'b1;
        open_p = p;
        open_h = h;
        repeat (h) @(posedge clk);
        #1 link = 1'b0;
        repeat (p - h - 1) @(posedge clk);
    endtask

    task automatic glitch_train();
        open = 1'b0;
        m = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 link = 1'b1;
            repeat (10) @(posedge clk);
            #1 link = 1'b0;
            repeat (9) @(posedge clk);
        end
    endtask

    // Monitor: pops expectations whenever the DUT strobes, flags strobes that are late or stray
    always @(negedge clk) begin
        exp_t e;
        int   t;
        if (nrst) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                checks++;
                failures++;
                $display("FAIL meas_valid_missing due=%0d now=%0d", e.due, cyc);
            end
            if (meas_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL meas_valid_unexpected freq=%0d high=%0d cycle=%0d",
                             freq_meas, high_meas, cyc);
                end else begin
                    e = sb.pop_front();
                    check("freq_meas", longint'(freq_meas), longint'(e.freq));
                    check("high_meas", longint'(high_meas), longint'(e.high));
                    check("locked_at_valid", longint'(locked), longint'(e.lck));
                    check("meas_valid_cycle", longint'(cyc), longint'(e.due));
                end
            end
            while (tq.size() > 0 && tq[0] < cyc) begin
                t = tq.pop_front();
                checks++;
                failures++;
                $display("FAIL timeout_missing due=%0d now=%0d", t, cyc);
            end
            if (timeout) begin
                if (tq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL timeout_unexpected cycle=%0d", cyc);
                end else begin
                    t = tq.pop_front();
                    check("timeout_cycle", longint'(cyc), longint'(t));
                    check("locked_at_timeout", longint'(locked), 0);
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int due;
        repeat (3) @(posedge clk);
        #1;
        check("reset_freq", longint'(freq_meas), 0);
        check("reset_high", longint'(high_meas), 0);
        check("reset_valid", longint'(meas_valid), 0);
        check("reset_locked", longint'(locked), 0);
        check("reset_timeout", longint'(timeout), 0);
        nrst = 1'b1;
        @(posedge clk);
        #1 swiptAlive = 1'b1;
        repeat (5) @(posedge clk);

        // 40 kHz square wave; lock from the 5th result
        repeat (6) emit(2500, 1250);
        // Period step to 2600 drops lock, then relocks
        repeat (6) emit(2600, 1300);
        // +/-8 cycle jitter keeps lock
        emit(2608, 1300);
        emit(2600, 1300);
        emit(2592, 1300);

        // Capturing rise, then link disabled 10 cycles after it: result must be dropped
        @(posedge clk);
        #1 link = 1'b1;
        open = 1'b0;
        repeat (12) @(posedge clk);
        #1 swiptAlive = 1'b0;
        have_prev = 1'b0;
        m = 0;
        repeat (5) @(posedge clk);
        #1 link = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("drop_locked", longint'(locked), 0);
        check("drop_freq_held", longint'(freq_meas), longint'(last_freq));
        check("drop_high_held", longint'(high_meas), longint'(last_high));
        swiptAlive = 1'b1;
        repeat (5) @(posedge clk);

        // 41 kHz narrow pulse, then high time beyond the 12-bit range
        emit(2439, 250);
        emit(9000, 5000);
        emit(2500, 1250);

        // Link held low after the last rise: loss of signal
        due = last_rise + 20003;
        tq.push_back(due);
        open = 1'b0;
        while (cyc < due + 5) @(posedge clk);
        #1;
        check("timeout_locked", longint'(locked), 0);
        have_prev = 1'b0;
        m = 0;

        // Glitch train gives no results; measuring resumes from ARM afterwards
        glitch_train();
        repeat (3) emit(2500, 1250);

        // Asynchronous reset in the middle of a measurement
        @(posedge clk);
        #3 nrst = 1'b0;
        #1;
        check("async_rst_freq", longint'(freq_meas), 0);
        check("async_rst_high", longint'(high_meas), 0);
        check("async_rst_locked", longint'(locked), 0);
        check("async_rst_valid", longint'(meas_valid), 0);
        check("async_rst_timeout", longint'(timeout), 0);
        open = 1'b0;
        repeat (5) @(posedge clk);
        #1 nrst = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("scoreboard_drained", longint'(sb.size()), 0);
        check("timeouts_drained", longint'(tq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
